// File: rtl/gb_alu_addp.sv
// gb_alu_addp: pipelined carry-lookahead add/sub, STAGES slices,
// one register stage per slice, valid/ready handshake and flush.
//
// Ports: i_clk, i_rst_n (async, active-low), i_flush (sync drop),
//   i_valid/o_ready input beat, i_a/i_b/i_c/i_sub operands,
//   o_valid/i_ready result beat, o_s sum, o_c raw carry-out,
//   o_z/o_n/o_v status flags.
// Build option: GB_ALU_ADDP_FLAGS_EN builds the flag pipeline;
//   without it o_z/o_n/o_v are tied to 0.

module gb_alu_addp #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_c,
  output logic             o_z,
  output logic             o_n,
  output logic             o_v
);

  localparam int SW = WIDTH / STAGES;

  if ((WIDTH % STAGES) != 0 || SW < 4) begin : g_bad_cfg
    $error("gb_alu_addp: bad WIDTH/STAGES");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin;

  assign en      = !o_valid || i_ready;
  assign o_ready = en;
  assign b_eff   = i_b ^ {WIDTH{i_sub}};
  assign cin     = i_c ^ i_sub;

  // Kogge-Stone prefix over one slice; returns carries c[0..SW],
  // c[i] being the carry into bit i.
  function automatic logic [SW:0] cla(
    input logic [SW-1:0] a,
    input logic [SW-1:0] b,
    input logic          c0
  );
    logic [SW-1:0] g, p, gn, pn;
    logic [SW:0]   c;
    g = a & b;
    p = a ^ b;
    for (int d = 1; d < SW; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < SW; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    c[0] = c0;
    for (int i = 0; i < SW; i++)
      c[i+1] = g[i] | (p[i] & c0);
    return c;
  endfunction

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_st
    // slices still waiting above this stage
    localparam int REM = STAGES - 1 - k;

    logic [SW-1:0]       sa, sb, s_slice;
    logic                sc;
    logic [SW:0]         cy;
    logic [(k+1)*SW-1:0] sum_d, sum_q;
    logic                vld_d, vld_q, cy_q;

    assign cy      = cla(sa, sb, sc);
    assign s_slice = sa ^ sb ^ cy[SW-1:0];

    if (k == 0) begin : g_in
      assign sa    = i_a[SW-1:0];
      assign sb    = b_eff[SW-1:0];
      assign sc    = cin;
      assign sum_d = s_slice;
      assign vld_d = i_valid;
    end else begin : g_in
      assign sa    = g_st[k-1].g_op.a_q[SW-1:0];
      assign sb    = g_st[k-1].g_op.b_q[SW-1:0];
      assign sc    = g_st[k-1].cy_q;
      assign sum_d = {s_slice, g_st[k-1].sum_q};
      assign vld_d = g_st[k-1].vld_q;
    end

    // operand skew: only the slices not yet added travel on
    if (REM > 0) begin : g_op
      logic [REM*SW-1:0] a_d, b_d, a_q, b_q;
      if (k == 0) begin : g_src
        assign a_d = i_a[WIDTH-1:SW];
        assign b_d = b_eff[WIDTH-1:SW];
      end else begin : g_src
        assign a_d = g_st[k-1].g_op.a_q[(REM+1)*SW-1:SW];
        assign b_d = g_st[k-1].g_op.b_q[(REM+1)*SW-1:SW];
      end
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        vld_q <= 1'b0;
        sum_q <= '0;
        cy_q  <= 1'b0;
      end else begin
        if (i_flush)
          vld_q <= 1'b0;
        else if (en)
          vld_q <= vld_d;
        if (en) begin
          sum_q <= sum_d;
          cy_q  <= cy[SW];
        end
      end
    end

`ifdef GB_ALU_ADDP_FLAGS_EN
    logic z_d, z_q;
    if (k == 0) begin : g_z
      assign z_d = (s_slice == '0);
    end else begin : g_z
      assign z_d = (s_slice == '0) & g_st[k-1].z_q;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
        z_q <= 1'b0;
      else if (en)
        z_q <= z_d;
    end
    // overflow only depends on the top slice
    if (k == STAGES - 1) begin : g_v
      logic v_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
          v_q <= 1'b0;
        else if (en)
          v_q <= cy[SW] ^ cy[SW-1];
      end
    end
`endif
  end

  assign o_valid = g_st[STAGES-1].vld_q;
  assign o_s     = g_st[STAGES-1].sum_q;
  assign o_c     = g_st[STAGES-1].cy_q;

`ifdef GB_ALU_ADDP_FLAGS_EN
  assign o_z = g_st[STAGES-1].z_q;
  assign o_n = o_s[WIDTH-1];
  assign o_v = g_st[STAGES-1].g_v.v_q;
`else
  assign o_z = 1'b0;
  assign o_n = 1'b0;
  assign o_v = 1'b0;
`endif

endmodule

// File: tb/tb_gb_alu_addp.sv
// tb_gb_alu_addp: random + directed bench for gb_alu_addp,
// scoreboard against an arithmetic reference model.

module tb_gb_alu_addp;

  localparam int W = 64;

`ifdef GB_ALU_ADDP_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         valid = 1'b0;
  logic         rdy = 1'b1;
  logic         c = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         r4_ready, r4_valid, r4_c, r4_z, r4_n, r4_v;
  logic [W-1:0] r4_s;
  logic         r2_ready, r2_valid, r2_c, r2_z, r2_n, r2_v;
  logic [W-1:0] r2_s;
  logic         r1_ready, r1_valid, r1_c, r1_z, r1_n, r1_v;
  logic [W-1:0] r1_s;

  always #5 clk = ~clk;

  gb_alu_addp #(.WIDTH(W), .STAGES(4)) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_valid(valid), .o_ready(r4_ready),
    .i_a(a), .i_b(b), .i_c(c), .i_sub(sub),
    .o_valid(r4_valid), .i_ready(rdy),
    .o_s(r4_s), .o_c(r4_c), .o_z(r4_z), .o_n(r4_n), .o_v(r4_v)
  );

  gb_alu_addp #(.WIDTH(W), .STAGES(2)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_valid(valid), .o_ready(r2_ready),
    .i_a(a), .i_b(b), .i_c(c), .i_sub(sub),
    .o_valid(r2_valid), .i_ready(rdy),
    .o_s(r2_s), .o_c(r2_c), .o_z(r2_z), .o_n(r2_n), .o_v(r2_v)
  );

  gb_alu_addp #(.WIDTH(W), .STAGES(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_valid(valid), .o_ready(r1_ready),
    .i_a(a), .i_b(b), .i_c(c), .i_sub(sub),
    .o_valid(r1_valid), .i_ready(rdy),
    .o_s(r1_s), .o_c(r1_c), .o_z(r1_z), .o_n(r1_n), .o_v(r1_v)
  );

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] s;
    logic         c, z, n, v;
  } res_t;

  function automatic res_t model(input logic [W-1:0] ma,
                                 input logic [W-1:0] mb,
                                 input logic mc, input logic ms);
    res_t         r;
    logic [W:0]   t;
    logic [W-1:0] be;
    be  = ms ? ~mb : mb;
    t   = {1'b0, ma} + {1'b0, be} + (W+1)'(mc ^ ms);
    r.s = t[W-1:0];
    r.c = t[W];
    r.z = FL & (r.s == '0);
    r.n = FL & r.s[W-1];
    r.v = FL & (ma[W-1] == be[W-1]) & (r.s[W-1] != ma[W-1]);
    return r;
  endfunction

  res_t expq[$];

  // scoreboard for the STAGES=4 instance
  always @(negedge clk) begin
    if (rst_n) begin
      res_t e;
      chk("ready", r4_ready, !(r4_valid && !rdy));
      if (r4_valid) begin
        if (expq.size() == 0) begin
          chk("spurious_valid", r4_valid, 0);
        end else begin
          e = expq[0];
          chk("sb_s", r4_s, e.s);
          chk("sb_c", r4_c, e.c);
          chk("sb_z", r4_z, e.z);
          chk("sb_n", r4_n, e.n);
          chk("sb_v", r4_v, e.v);
          if (rdy) begin
            void'(expq.pop_front());
            pops++;
          end
        end
      end
      if (flush)
        expq.delete();
      else if (valid && r4_ready)
        expq.push_back(model(a, b, c, sub));
    end
  end

  task automatic one(input string tag,
                     input logic [W-1:0] ta, input logic [W-1:0] tb,
                     input logic tc, input logic ts,
                     input logic [W-1:0] es, input logic ec,
                     input logic ez, input logic en_, input logic ev);
    int n;
    rdy = 1'b1;
    @(posedge clk); #1;
    a = ta; b = tb; c = tc; sub = ts; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    n = 0;
    while (!r4_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 3);
    chk({tag, "_s"}, r4_s, es);
    chk({tag, "_c"}, r4_c, ec);
    chk({tag, "_z"}, r4_z, ez & FL);
    chk({tag, "_n"}, r4_n, en_ & FL);
    chk({tag, "_v"}, r4_v, ev & FL);
  endtask

  task automatic rnd_beat();
    a   = {$urandom, $urandom};
    b   = ($urandom_range(0, 3) == 0) ? ~a : {$urandom, $urandom};
    c   = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  logic [W-1:0] ones;
  int           l1, l2, l4;
  logic [W-1:0] s1, s2, s4;
  logic         c1, c2, c4;

  initial begin
    ones = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", r4_valid, 0);
    chk("rst_ready", r4_ready, 1);
    chk("rst_s", r4_s, 0);
    rst_n = 1'b1;

    one("max_p1", ones, 64'd1, 1'b0, 1'b0,
        64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    one("sub5_7", 64'd5, 64'd7, 1'b0, 1'b1,
        64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    one("sub5_7b", 64'd5, 64'd7, 1'b1, 1'b1,
        64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b1, 1'b0);
    one("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
        64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);

    // random stream, i_ready toggling every 3 cycles
    begin
      int sent, cyc, p0;
      logic acc;
      p0 = pops + (r4_valid ? 1 : 0);
      sent = 0;
      cyc = 0;
      @(posedge clk); #1;
      rnd_beat();
      valid = 1'b1;
      while (sent < 16 && cyc < 500) begin
        @(negedge clk);
        acc = r4_ready;
        @(posedge clk); #1;
        cyc++;
        if (acc) begin
          sent++;
          rnd_beat();
        end
        if (sent == 16) valid = 1'b0;
        if (cyc % 3 == 0) rdy = ~rdy;
      end
      valid = 1'b0;
      rdy = 1'b1;
      cyc = 0;
      while ((expq.size() != 0 || r4_valid) && cyc < 50) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("drain_left", expq.size(), 0);
      chk("stream_cnt", pops - p0, 16);
      repeat (4) @(posedge clk);
    end

    // flush with three beats in flight plus one presented
    #1;
    for (int i = 0; i < 3; i++) begin
      rnd_beat();
      valid = 1'b1;
      @(posedge clk); #1;
    end
    rnd_beat();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    valid = 1'b0;
    repeat (6) begin
      chk("flush_quiet", r4_valid, 0);
      @(posedge clk); #1;
    end
    one("post_flush", 64'd10, 64'd20, 1'b0, 1'b0,
        64'd30, 1'b0, 1'b0, 1'b0, 1'b0);

    // async reset in the middle of a stream
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      a = 64'd100 + 64'(i);
      b = 64'd1; c = 1'b0; sub = 1'b0;
      valid = 1'b1;
      @(posedge clk);
      if (i < 3) #1;
    end
    #3;
    rst_n = 1'b0;
    #1;
    expq.delete();
    valid = 1'b0;
    chk("arst_valid", r4_valid, 0);
    chk("arst_s", r4_s, 0);
    chk("arst_c", r4_c, 0);
    chk("arst_z", r4_z, 0);
    chk("arst_n", r4_n, 0);
    chk("arst_v", r4_v, 0);
    chk("arst_valid2", r2_valid, 0);
    chk("arst_s1", r1_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", r4_ready, 1);
    one("add3_4", 64'd3, 64'd4, 1'b0, 1'b0,
        64'd7, 1'b0, 1'b0, 1'b0, 1'b0);

    // carry ripple on all three depths together
    @(posedge clk); #1;
    a = ones; b = 64'd1; c = 1'b0; sub = 1'b0;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    l1 = -1; l2 = -1; l4 = -1;
    s1 = '1; s2 = '1; s4 = '1;
    c1 = 1'b0; c2 = 1'b0; c4 = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (r1_valid && l1 < 0) begin l1 = n; s1 = r1_s; c1 = r1_c; end
      if (r2_valid && l2 < 0) begin l2 = n; s2 = r2_s; c2 = r2_c; end
      if (r4_valid && l4 < 0) begin l4 = n; s4 = r4_s; c4 = r4_c; end
      @(posedge clk); #1;
    end
    chk("cy1_lat", W'(l1), 0);
    chk("cy1_s", s1, 0);
    chk("cy1_c", c1, 1);
    chk("cy2_lat", W'(l2), 1);
    chk("cy2_s", s2, 0);
    chk("cy2_c", c2, 1);
    chk("cy4_lat", W'(l4), 3);
    chk("cy4_s", s4, 0);
    chk("cy4_c", c4, 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
